// File: rtl/fattree_endpoint_injector.sv
// fattree_endpoint_injector: packetizes descriptors plus a payload stream into
// head/body/tail flits on one credit-flow-controlled, round-robin VC of a fat-tree leaf port.
module fattree_endpoint_injector #(
    parameter  int K       = 2,
    parameter  int L       = 3,
    parameter  int V       = 2,
    parameter  int B       = 4,
    parameter  int Fpay    = 32,
    parameter  int MAX_LEN = 16,
    parameter  int SRC_ID  = 0,
    localparam int Kw      = (K <= 2) ? 1 : $clog2(K),
    localparam int EAw     = Kw * L,
    localparam int LENw    = $clog2(MAX_LEN + 1),
    localparam int Cw      = $clog2(B + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pkt_valid,
    output logic            pkt_ready,
    input  logic [EAw-1:0]  pkt_dest,
    input  logic [LENw-1:0] pkt_len,
    input  logic            data_valid,
    output logic            data_ready,
    input  logic [Fpay-1:0] data_in,
    output logic            flit_wr,
    output logic            flit_hdr,
    output logic            flit_tail,
    output logic [V-1:0]    flit_vc,
    output logic [Fpay-1:0] flit_data,
    input  logic [V-1:0]    credit_in,
    output logic            err_pulse,
    output logic            busy
);
    localparam int NE = K ** L;
    localparam int PW = (V > 1) ? $clog2(V) : 1;

    typedef enum logic [1:0] {IDLE, VCSEL, HEAD, BODY} state_e;

    state_e                  state_q, state_d;
    logic [EAw-1:0]          dest_q, dest_d;
    logic [LENw-1:0]         len_q, len_d, rem_q, rem_d;
    logic [PW-1:0]           vc_q, vc_d, ptr_q, ptr_d, pick;
    logic [V-1:0][Cw-1:0]    cred_q, cred_d;
    logic                    wr_q, wr_d, hdr_q, hdr_d, tail_q, tail_d, err_q, err_d;
    logic [V-1:0]            fvc_q, fvc_d;
    logic [Fpay-1:0]         fdata_q, fdata_d, head_word;
    logic                    desc_ok, found, cred_ok, send, last;

    // Base-K digit i of the endpoint index lands in its own Kw-bit field.
    function automatic logic [EAw-1:0] encode(input logic [31:0] idx);
        logic [31:0]    t;
        logic [EAw-1:0] r;
        t = idx;
        r = '0;
        for (int i = 0; i < L; i++) begin
            r[i*Kw +: Kw] = Kw'(t % K);
            t = t / K;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            vc_q    <= '0;
            ptr_q   <= '0;
            for (int v = 0; v < V; v++) cred_q[v] <= Cw'(B);
            wr_q    <= 1'b0;
            hdr_q   <= 1'b0;
            tail_q  <= 1'b0;
            fvc_q   <= '0;
            fdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            vc_q    <= vc_d;
            ptr_q   <= ptr_d;
            cred_q  <= cred_d;
            wr_q    <= wr_d;
            hdr_q   <= hdr_d;
            tail_q  <= tail_d;
            fvc_q   <= fvc_d;
            fdata_q <= fdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        desc_ok = int'(pkt_dest) < NE && pkt_len != '0 && int'(pkt_len) <= MAX_LEN;
        found   = 1'b0;
        pick    = ptr_q;
        // Descending scan so the VC closest after the pointer wins.
        for (int i = V - 1; i >= 0; i--) begin
            if (cred_q[(int'(ptr_q) + i) % V] != '0) begin
                found = 1'b1;
                pick  = PW'((int'(ptr_q) + i) % V);
            end
        end
        state_d = state_q;
        dest_d  = dest_q;
        len_d   = len_q;
        rem_d   = rem_q;
        vc_d    = vc_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: if (pkt_valid && desc_ok) begin
                dest_d  = pkt_dest;
                len_d   = pkt_len;
                rem_d   = pkt_len;
                state_d = VCSEL;
            end
            VCSEL: if (found) begin
                vc_d    = pick;
                ptr_d   = (int'(pick) + 1 == V) ? '0 : pick + 1'b1;
                state_d = HEAD;
            end
            HEAD, BODY: if (send) begin
                rem_d   = rem_q - 1'b1;
                state_d = last ? IDLE : BODY;
            end
        endcase
    end

    always_comb begin
        cred_ok    = cred_q[vc_q] != '0;
        send       = cred_ok && (state_q == HEAD || (state_q == BODY && data_valid));
        last       = rem_q == LENw'(1);
        data_ready = state_q == BODY && data_valid && cred_ok;
        pkt_ready  = state_q == IDLE;
        busy       = state_q != IDLE;
        head_word  = '0;
        head_word[EAw-1:0]          = encode(32'(dest_q));
        head_word[EAw +: EAw]       = encode(32'(SRC_ID));
        head_word[2*EAw +: LENw]    = len_q;
        wr_d    = send;
        hdr_d   = send && state_q == HEAD;
        tail_d  = send && last;
        fvc_d   = send ? (V'(1) << vc_q) : '0;
        fdata_d = !send ? '0 : (state_q == HEAD) ? head_word : data_in;
        err_d   = state_q == IDLE && pkt_valid && !desc_ok;
        cred_d  = cred_q;
        // A return and a send in the same cycle cancel; returns at B are dropped.
        for (int v = 0; v < V; v++) begin
            if (credit_in[v] && !(send && int'(vc_q) == v) && cred_q[v] != Cw'(B))
                cred_d[v] = cred_q[v] + 1'b1;
            else if (!credit_in[v] && send && int'(vc_q) == v)
                cred_d[v] = cred_q[v] - 1'b1;
        end
    end

    assign flit_wr   = wr_q;
    assign flit_hdr  = hdr_q;
    assign flit_tail = tail_q;
    assign flit_vc   = fvc_q;
    assign flit_data = fdata_q;
    assign err_pulse = err_q;

endmodule

// File: tb/tb_fattree_endpoint_injector.sv
// tb_fattree_endpoint_injector: directed checks of the injector in its default
// K=2/L=3 form plus a K=3/L=2 instance for the digit encoding and range check.
`timescale 1ns/1ps
module tb_fattree_endpoint_injector;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        pkt_valid, pkt_ready, data_valid, data_ready;
    logic        flit_wr, flit_hdr, flit_tail, err_pulse, busy;
    logic [2:0]  pkt_dest;
    logic [4:0]  pkt_len;
    logic [31:0] data_in, flit_data;
    logic [1:0]  flit_vc, credit_in;

    logic        k_valid, k_ready, k_dready, k_wr, k_hdr, k_tail, k_err, k_busy;
    logic [3:0]  k_dest;
    logic [4:0]  k_len;
    logic [31:0] k_data;
    logic [1:0]  k_vc;

    fattree_endpoint_injector u_dut (
        .clk(clk), .reset(reset),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dest(pkt_dest), .pkt_len(pkt_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .flit_wr(flit_wr), .flit_hdr(flit_hdr), .flit_tail(flit_tail),
        .flit_vc(flit_vc), .flit_data(flit_data),
        .credit_in(credit_in), .err_pulse(err_pulse), .busy(busy)
    );

    fattree_endpoint_injector #(.K(3), .L(2), .SRC_ID(7)) u_k3 (
        .clk(clk), .reset(reset),
        .pkt_valid(k_valid), .pkt_ready(k_ready), .pkt_dest(k_dest), .pkt_len(k_len),
        .data_valid(1'b0), .data_ready(k_dready), .data_in(32'h0),
        .flit_wr(k_wr), .flit_hdr(k_hdr), .flit_tail(k_tail),
        .flit_vc(k_vc), .flit_data(k_data),
        .credit_in(2'b00), .err_pulse(k_err), .busy(k_busy)
    );

    typedef struct packed {
        logic        hdr;
        logic        tail;
        logic [1:0]  vc;
        logic [31:0] data;
    } flit_t;

    flit_t q[$];
    int    base = 0;
    int    checks = 0;
    int    failures = 0;

    always @(negedge clk) if (reset && flit_wr) q.push_back('{flit_hdr, flit_tail, flit_vc, flit_data});

    function automatic int nfl();
        return q.size() - base;
    endfunction

    function automatic flit_t fl(input int i);
        return (base + i < q.size()) ? q[base + i] : '0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        pkt_valid = 1'b0;
        data_valid = 1'b0;
        credit_in = '0;
        k_valid = 1'b0;
        cyc(2);
        base = q.size();
        reset = 1'b1;
        cyc(1);
    endtask

    task automatic send(input logic [2:0] d, input logic [4:0] l);
        pkt_valid = 1'b1;
        pkt_dest = d;
        pkt_len = l;
        cyc(1);
        pkt_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            cyc(1);
            n++;
        end
        check(tag, busy, 0);
        cyc(1);
    endtask

    initial begin
        pkt_valid = 0; pkt_dest = 0; pkt_len = 0; data_valid = 0; data_in = 0; credit_in = 0;
        k_valid = 0; k_dest = 0; k_len = 0;
        cyc(2);
        check("rst_ready", pkt_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_wr", flit_wr, 0);
        check("rst_err", err_pulse, 0);
        check("rst_vc", flit_vc, 0);
        check("rst_data", flit_data, 0);
        check("rst_dready", data_ready, 0);

        // single-flit packet, dest 6, latency 3
        do_reset;
        send(3'd6, 5'd1);
        check("single_ready_low", pkt_ready, 0);
        check("single_busy", busy, 1);
        cyc(1);
        check("single_early", flit_wr, 0);
        cyc(1);
        check("single_wr", flit_wr, 1);
        check("single_hdr", flit_hdr, 1);
        check("single_tail", flit_tail, 1);
        check("single_vc", flit_vc, 2'b01);
        check("single_data", flit_data, 32'h46);
        cyc(1);
        check("single_idle", busy, 0);
        check("single_wr_off", flit_wr, 0);

        // round robin with full credits
        do_reset;
        data_valid = 1'b1;
        data_in = 32'h1111_0001;
        send(3'd7, 5'd2);
        wait_idle("rr1_idle");
        data_in = 32'h2222_0002;
        send(3'd3, 5'd2);
        wait_idle("rr2_idle");
        check("rr_count", nfl(), 4);
        check("rr_p1_head", {fl(0).hdr, fl(0).tail, fl(0).vc}, 4'b1001);
        check("rr_p1_hdata", fl(0).data, 32'h87);
        check("rr_p1_tail", {fl(1).hdr, fl(1).tail, fl(1).vc}, 4'b0101);
        check("rr_p1_bdata", fl(1).data, 32'h1111_0001);
        check("rr_p2_head", {fl(2).hdr, fl(2).vc}, 3'b110);
        check("rr_p2_tail", {fl(3).tail, fl(3).vc}, 3'b110);
        check("rr_p2_bdata", fl(3).data, 32'h2222_0002);

        // round robin skips a VC with no credit
        do_reset;
        data_valid = 1'b1;
        send(3'd1, 5'd4);
        wait_idle("skip_a");
        send(3'd2, 5'd4);
        wait_idle("skip_b");
        credit_in = 2'b01;
        cyc(4);
        credit_in = 2'b00;
        send(3'd4, 5'd2);
        wait_idle("skip_c");
        send(3'd5, 5'd2);
        wait_idle("skip_d");
        check("skip_count", nfl(), 12);
        check("skip_a_vc", fl(0).vc, 2'b01);
        check("skip_b_vc", fl(4).vc, 2'b10);
        check("skip_c_vc", fl(8).vc, 2'b01);
        check("skip_d_vc", {fl(10).hdr, fl(10).vc}, 3'b101);

        // credit exhaustion; returns at B are dropped first
        do_reset;
        credit_in = 2'b01;
        cyc(3);
        credit_in = 2'b00;
        data_valid = 1'b1;
        send(3'd5, 5'd6);
        cyc(15);
        check("exh_count4", nfl(), 4);
        check("exh_stall_busy", busy, 1);
        check("exh_stall_wr", flit_wr, 0);
        check("exh_stall_dready", data_ready, 0);
        check("exh_no_tail", fl(3).tail, 0);
        credit_in = 2'b01;
        cyc(1);
        credit_in = 2'b00;
        cyc(4);
        check("exh_count5", nfl(), 5);
        credit_in = 2'b01;
        cyc(1);
        credit_in = 2'b00;
        wait_idle("exh_idle");
        check("exh_count6", nfl(), 6);
        check("exh_f5_tail", fl(4).tail, 0);
        check("exh_f6_tail", {fl(5).hdr, fl(5).tail}, 2'b01);

        // simultaneous return and send at credit 2
        do_reset;
        send(3'd3, 5'd8);
        cyc(5);
        check("sim_dready_off", data_ready, 0);
        data_valid = 1'b1;
        #1;
        check("sim_dready_on", data_ready, 1);
        cyc(1);
        credit_in = 2'b01;
        cyc(1);
        credit_in = 2'b00;
        cyc(12);
        check("sim_count", nfl(), 5);
        check("sim_busy", busy, 1);

        // reset in the middle of a body
        do_reset;
        data_valid = 1'b1;
        send(3'd2, 5'd5);
        for (int n = 0; n < 20 && nfl() < 2; n++) cyc(1);
        check("mid_reached2", nfl() >= 2, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_wr_off", flit_wr, 0);
        check("mid_ready", pkt_ready, 1);
        check("mid_busy", busy, 0);
        cyc(1);
        base = q.size();
        reset = 1'b1;
        cyc(1);
        send(3'd0, 5'd2);
        wait_idle("mid_p1");
        send(3'd1, 5'd3);
        wait_idle("mid_p2");
        send(3'd2, 5'd2);
        wait_idle("mid_p3");
        check("mid_count", nfl(), 7);
        check("mid_p1_head", {fl(0).hdr, fl(0).vc}, 3'b101);
        check("mid_p2_vc", fl(2).vc, 2'b10);
        check("mid_p3_vc", fl(5).vc, 2'b01);

        // rejected descriptors
        do_reset;
        send(3'd3, 5'd0);
        check("err_len0_pulse", err_pulse, 1);
        check("err_len0_busy", busy, 0);
        cyc(1);
        check("err_len0_once", err_pulse, 0);
        send(3'd3, 5'd17);
        check("err_len17_pulse", err_pulse, 1);
        check("err_len17_ready", pkt_ready, 1);
        cyc(1);
        check("err_len17_once", err_pulse, 0);
        cyc(3);
        check("err_no_flits", nfl(), 0);
        send(3'd7, 5'd16);
        check("len16_accepted", {busy, err_pulse}, 2'b10);

        // K=3, L=2 encoding and out-of-range destination
        do_reset;
        k_valid = 1'b1; k_dest = 4'd9; k_len = 5'd1;
        cyc(1);
        k_valid = 1'b0;
        check("k3_dest9_err", k_err, 1);
        check("k3_dest9_busy", k_busy, 0);
        k_valid = 1'b1; k_dest = 4'd5; k_len = 5'd1;
        cyc(1);
        k_valid = 1'b0;
        check("k3_ready_low", k_ready, 0);
        cyc(2);
        check("k3_wr", k_wr, 1);
        check("k3_flags", {k_hdr, k_tail, k_vc}, 4'b1101);
        check("k3_data", k_data, 32'h196);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
